axi_rd_arbiter: RTL and testbench

AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

---
 rtl/axi_rd_arbiter.sv | 177 +++++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arbiter.sv
// Two-requester AXI read arbiter: round-robin grant, one burst outstanding,
// AR and R channels steered to the granted requester, sticky burst-length check.
module axi_rd_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 256,
  parameter int ID_W   = 6,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  // requester 0 (feature fetch)
  input  logic              s0_ar_arvalid,
  output logic              s0_ar_arready,
  input  logic [ID_W-1:0]   s0_ar_arid,
  input  logic [LEN_W-1:0]  s0_ar_arlen,
  input  logic [ADDR_W-1:0] s0_ar_araddr,
  output logic              s0_r_rvalid,
  input  logic              s0_r_rready,
  output logic [ID_W-1:0]   s0_r_rid,
  output logic              s0_r_rlast,
  output logic [DATA_W-1:0] s0_r_rdata,
  // requester 1 (weight fetch)
  input  logic              s1_ar_arvalid,
  output logic              s1_ar_arready,
  input  logic [ID_W-1:0]   s1_ar_arid,
  input  logic [LEN_W-1:0]  s1_ar_arlen,
  input  logic [ADDR_W-1:0] s1_ar_araddr,
  output logic              s1_r_rvalid,
  input  logic              s1_r_rready,
  output logic [ID_W-1:0]   s1_r_rid,
  output logic              s1_r_rlast,
  output logic [DATA_W-1:0] s1_r_rdata,
  // shared memory port
  output logic              m_ar_arvalid,
  input  logic              m_ar_arready,
  output logic [ID_W-1:0]   m_ar_arid,
  output logic [LEN_W-1:0]  m_ar_arlen,
  output logic [ADDR_W-1:0] m_ar_araddr,
  input  logic              m_r_rvalid,
  output logic              m_r_rready,
  input  logic [ID_W-1:0]   m_r_rid,
  input  logic              m_r_rlast,
  input  logic [DATA_W-1:0] m_r_rdata,
  // status
  output logic [1:0]        grant,
  output logic              busy,
  output logic              err_len,
  output logic [1:0]        dbg_state_o
);

  // Handshake rule on every channel: a transfer happens on a rising edge where
  // valid and ready are both high; valid never depends on ready.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic             ptr_q, ptr_d;
  logic [LEN_W:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             err_q, err_d;
  logic             sel;
  logic             ar_hs;
  logic             r_hs;

  // sel=1 steers everything to requester 1; only meaningful while granted
  assign sel = grant_q[1];

  assign s0_r_rid   = m_r_rid;
  assign s0_r_rlast = m_r_rlast;
  assign s0_r_rdata = m_r_rdata;
  assign s1_r_rid   = m_r_rid;
  assign s1_r_rlast = m_r_rlast;
  assign s1_r_rdata = m_r_rdata;

  assign grant       = grant_q;
  assign busy        = (state_q != S_IDLE);
  assign err_len     = err_q;
  assign dbg_state_o = state_q;

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    len_d         = len_q;
    err_d         = err_q;
    m_ar_arvalid  = 1'b0;
    m_ar_arid     = sel ? s1_ar_arid   : s0_ar_arid;
    m_ar_arlen    = sel ? s1_ar_arlen  : s0_ar_arlen;
    m_ar_araddr   = sel ? s1_ar_araddr : s0_ar_araddr;
    s0_ar_arready = 1'b0;
    s1_ar_arready = 1'b0;
    m_r_rready    = 1'b0;
    s0_r_rvalid   = 1'b0;
    s1_r_rvalid   = 1'b0;
    ar_hs         = 1'b0;
    r_hs          = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (s0_ar_arvalid || s1_ar_arvalid) begin
          // ptr_q names the last requester served; the other one wins a tie
          if (s0_ar_arvalid && s1_ar_arvalid) grant_d = ptr_q ? 2'b01 : 2'b10;
          else                                grant_d = s0_ar_arvalid ? 2'b01 : 2'b10;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        m_ar_arvalid  = sel ? s1_ar_arvalid : s0_ar_arvalid;
        s0_ar_arready = !sel && m_ar_arready;
        s1_ar_arready = sel && m_ar_arready;
        ar_hs         = m_ar_arvalid && m_ar_arready;
        if (ar_hs) begin
          len_d   = m_ar_arlen;
          cnt_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        m_r_rready  = sel ? s1_r_rready : s0_r_rready;
        s0_r_rvalid = !sel && m_r_rvalid;
        s1_r_rvalid = sel && m_r_rvalid;
        r_hs        = m_r_rvalid && m_r_rready;
        if (r_hs) begin
          cnt_d = cnt_q + {{LEN_W{1'b0}}, 1'b1};
          if (m_r_rlast) begin
            if (cnt_q != {1'b0, len_q}) err_d = 1'b1;
            ptr_d   = sel;
            grant_d = 2'b00;
            state_d = S_IDLE;
          end else if (cnt_q == {1'b0, len_q}) begin
            // final expected beat without rlast: flag it and keep draining
            err_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = 2'b00;
      end
    endcase

    // no handshake may be offered while reset is held, even mid-burst
    if (!rst_n) begin
      m_ar_arvalid  = 1'b0;
      s0_ar_arready = 1'b0;
      s1_ar_arready = 1'b0;
      m_r_rready    = 1'b0;
      s0_r_rvalid   = 1'b0;
      s1_r_rvalid   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      grant_q <= 2'b00;
      ptr_q   <= 1'b1;
      cnt_q   <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: cycle-based requester/memory driver, per-requester
// expected-beat queues drained by a monitor, and a round-robin grant model.
module tb_axi_rd_arbiter;

  localparam int ADDR_W = 32;
  localparam int DW     = 64;
  localparam int ID_W   = 6;
  localparam int LEN_W  = 8;
  localparam int W      = 1 + ID_W + DW;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [LEN_W-1:0]  len;
    logic [ADDR_W-1:0] addr;
  } cmd_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // requester side
  logic [1:0]        s_arvalid;
  logic [1:0]        s_arready;
  logic [ID_W-1:0]   s_arid   [2];
  logic [LEN_W-1:0]  s_arlen  [2];
  logic [ADDR_W-1:0] s_araddr [2];
  logic [1:0]        s_rvalid;
  logic [1:0]        s_rready;
  logic [ID_W-1:0]   s_rid    [2];
  logic [1:0]        s_rlast;
  logic [DW-1:0]     s_rdata  [2];

  // memory side
  logic              m_ar_arvalid, m_ar_arready;
  logic [ID_W-1:0]   m_ar_arid;
  logic [LEN_W-1:0]  m_ar_arlen;
  logic [ADDR_W-1:0] m_ar_araddr;
  logic              m_r_rvalid, m_r_rready, m_r_rlast;
  logic [ID_W-1:0]   m_r_rid;
  logic [DW-1:0]     m_r_rdata;

  logic [1:0] grant;
  logic       busy, err_len;
  logic [1:0] dbg_state;

  axi_rd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DW), .ID_W(ID_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .s0_ar_arvalid(s_arvalid[0]), .s0_ar_arready(s_arready[0]), .s0_ar_arid(s_arid[0]),
    .s0_ar_arlen(s_arlen[0]), .s0_ar_araddr(s_araddr[0]),
    .s0_r_rvalid(s_rvalid[0]), .s0_r_rready(s_rready[0]), .s0_r_rid(s_rid[0]),
    .s0_r_rlast(s_rlast[0]), .s0_r_rdata(s_rdata[0]),
    .s1_ar_arvalid(s_arvalid[1]), .s1_ar_arready(s_arready[1]), .s1_ar_arid(s_arid[1]),
    .s1_ar_arlen(s_arlen[1]), .s1_ar_araddr(s_araddr[1]),
    .s1_r_rvalid(s_rvalid[1]), .s1_r_rready(s_rready[1]), .s1_r_rid(s_rid[1]),
    .s1_r_rlast(s_rlast[1]), .s1_r_rdata(s_rdata[1]),
    .m_ar_arvalid(m_ar_arvalid), .m_ar_arready(m_ar_arready), .m_ar_arid(m_ar_arid),
    .m_ar_arlen(m_ar_arlen), .m_ar_araddr(m_ar_araddr),
    .m_r_rvalid(m_r_rvalid), .m_r_rready(m_r_rready), .m_r_rid(m_r_rid),
    .m_r_rlast(m_r_rlast), .m_r_rdata(m_r_rdata),
    .grant(grant), .busy(busy), .err_len(err_len), .dbg_state_o(dbg_state)
  );

  // bench controls (written by the main sequence only)
  logic ar_en = 1'b1;
  logic spur = 1'b0;
  logic rand_mode = 1'b0;
  int   mem_short = 0;

  // scoreboard state
  cmd_t        cmd_q0[$], cmd_q1[$];
  logic [W-1:0] exp_q0[$], exp_q1[$];
  int n_checks = 0;
  int n_err = 0;
  int beats_seen [2] = '{0, 0};

  logic              mem_busy = 1'b0;
  logic [ADDR_W-1:0] mem_addr = '0;
  logic [ID_W-1:0]   mem_id = '0;
  int                mem_beat = 0;
  int                mem_nb = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int qsize(input int n);
    return (n == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic logic [W-1:0] qpop(input int n);
    if (n == 0) return exp_q0.pop_front();
    return exp_q1.pop_front();
  endfunction

  task automatic push_cmd(input int n, input logic [ID_W-1:0] id,
                          input logic [LEN_W-1:0] len, input logic [ADDR_W-1:0] addr);
    cmd_t c;
    c.id = id; c.len = len; c.addr = addr;
    if (n == 0) cmd_q0.push_back(c);
    else        cmd_q1.push_back(c);
  endtask

  // driver: requesters and memory, all updated just after each rising edge
  initial begin : bfm
    logic rst_s, ar_hs, r_hs;
    logic [1:0] s_hs;
    logic [ADDR_W-1:0] c_addr;
    logic [ID_W-1:0] c_id;
    logic [LEN_W-1:0] c_len;
    logic [W-1:0] v;
    int gap [2];
    int nb;
    cmd_t cur [2];
    gap = '{0, 0};
    s_arvalid = 2'b00; s_rready = 2'b11;
    for (int n = 0; n < 2; n++) begin
      s_arid[n] = '0; s_arlen[n] = '0; s_araddr[n] = '0; cur[n] = '0;
    end
    m_ar_arready = 1'b0; m_r_rvalid = 1'b0; m_r_rid = '0; m_r_rlast = 1'b0; m_r_rdata = '0;
    forever begin
      @(negedge clk);
      rst_s  = rst_n;
      ar_hs  = m_ar_arvalid & m_ar_arready;
      c_addr = m_ar_araddr; c_id = m_ar_arid; c_len = m_ar_arlen;
      r_hs   = m_r_rvalid & m_r_rready;
      s_hs   = s_arvalid & s_arready;
      @(posedge clk); #1;
      if (!rst_s) mem_busy = 1'b0;
      else if (ar_hs) begin
        mem_busy = 1'b1; mem_addr = c_addr; mem_id = c_id; mem_beat = 0;
        mem_nb = (mem_short != 0) ? mem_short : int'(c_len) + 1;
      end else if (r_hs && mem_busy) begin
        if (mem_beat == mem_nb - 1) mem_busy = 1'b0;
        else mem_beat++;
      end
      for (int n = 0; n < 2; n++) begin
        if (s_hs[n] && rst_s) begin
          s_arvalid[n] = 1'b0;
          nb = (mem_short != 0) ? mem_short : int'(cur[n].len) + 1;
          for (int i = 0; i < nb; i++) begin
            v = {(i == nb - 1), cur[n].id, cur[n].addr, 32'(i)};
            if (n == 0) exp_q0.push_back(v);
            else        exp_q1.push_back(v);
          end
          gap[n] = rand_mode ? int'($urandom_range(0, 3)) : 0;
        end else if (!s_arvalid[n]) begin
          if (gap[n] > 0) gap[n]--;
          else if (n == 0 && cmd_q0.size() != 0) begin
            cur[0] = cmd_q0.pop_front(); s_arvalid[0] = 1'b1;
          end else if (n == 1 && cmd_q1.size() != 0) begin
            cur[1] = cmd_q1.pop_front(); s_arvalid[1] = 1'b1;
          end
          s_arid[n] = cur[n].id; s_arlen[n] = cur[n].len; s_araddr[n] = cur[n].addr;
        end
        s_rready[n] = rand_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
      end
      m_ar_arready = ar_en && !mem_busy && (!rand_mode || $urandom_range(0, 1) == 1);
      m_r_rvalid   = spur || (mem_busy && (!rand_mode || $urandom_range(0, 3) != 0));
      m_r_rdata    = {mem_addr, 32'(mem_beat)};
      m_r_rid      = mem_id;
      m_r_rlast    = mem_busy && (mem_beat == mem_nb - 1);
    end
  end

  // monitor: each beat a requester accepts must be the head of its own queue
  initial begin : mon
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int n = 0; n < 2; n++) begin
          chk($sformatf("stray_beat_s%0d", n), s_rvalid[n] && (qsize(n) == 0), 1'b0);
          if (s_rvalid[n] && s_rready[n] && qsize(n) != 0) begin
            e = qpop(n);
            chk($sformatf("rbeat_s%0d", n), {s_rlast[n], s_rid[n], s_rdata[n]}, e);
            beats_seen[n]++;
          end
        end
      end
    end
  end

  // grant model: round-robin from "last served", one-cycle latency out of idle
  initial begin : arb_model
    logic [1:0] req_p, grant_p, exp_g;
    logic busy_p, rst_p, rr_last;
    req_p = 2'b00; grant_p = 2'b00; busy_p = 1'b0; rst_p = 1'b0; rr_last = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_p) rr_last = 1'b1;
      else if (!busy_p) begin
        if (req_p == 2'b00) begin
          chk("idle_grant", grant, 2'b00);
          chk("idle_busy", busy, 1'b0);
        end else begin
          exp_g = (req_p == 2'b11) ? (rr_last ? 2'b01 : 2'b10) : req_p;
          chk("rr_grant", grant, exp_g);
          chk("grant_busy", busy, 1'b1);
          rr_last = (exp_g == 2'b10);
        end
      end else begin
        if (busy) chk("grant_hold", grant, grant_p);
        else      chk("grant_release", grant, 2'b00);
      end
      req_p = s_arvalid; grant_p = grant; busy_p = busy; rst_p = rst_n;
    end
  end

  task automatic wait_idle(input int limit);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < limit && !ok; k++) begin
      @(negedge clk);
      ok = (cmd_q0.size() == 0) && (cmd_q1.size() == 0) && (s_arvalid == 2'b00) &&
           (exp_q0.size() == 0) && (exp_q1.size() == 0) && !busy && !mem_busy;
    end
    chk("idle_timeout", ok, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, "_m_arvalid"}, m_ar_arvalid, 1'b0);
    chk({nm, "_m_rready"}, m_r_rready, 1'b0);
    chk({nm, "_s_arready"}, s_arready, 2'b00);
    chk({nm, "_s_rvalid"}, s_rvalid, 2'b00);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int base;
    bit seen;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_grant", grant, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err_len, 1'b0);
    chk_quiet("rst");
    @(posedge clk); #1 rst_n = 1'b1;

    // single s0 burst of four beats
    push_cmd(0, 6'h01, 8'd3, 32'h0000_0100);
    wait_idle(200);
    chk("s0_only_err", err_len, 1'b0);
    chk("s0_only_beats", beats_seen[0], 4);
    chk("s0_only_s1_beats", beats_seen[1], 0);

    // simultaneous requests from reset: s0, then s1, then s0 again
    do_reset();
    push_cmd(0, 6'h02, 8'd1, 32'h0000_0200);
    push_cmd(1, 6'h12, 8'd2, 32'h1000_0200);
    wait_idle(300);
    push_cmd(0, 6'h03, 8'd0, 32'h0000_0300);
    push_cmd(1, 6'h13, 8'd0, 32'h1000_0300);
    wait_idle(300);

    // short burst from memory sets the sticky length error
    mem_short = 6;
    push_cmd(1, 6'h21, 8'd7, 32'h2000_0000);
    wait_idle(300);
    mem_short = 0;
    chk("short_err", err_len, 1'b1);
    push_cmd(0, 6'h04, 8'd2, 32'h0000_0400);
    wait_idle(300);
    chk("short_err_sticky", err_len, 1'b1);

    // address channel held off while s1 waits behind s0
    ar_en = 1'b0;
    push_cmd(0, 6'h05, 8'd1, 32'h0000_0500);
    repeat (3) @(posedge clk);
    #1 push_cmd(1, 6'h15, 8'd1, 32'h1000_0500);
    repeat (5) begin
      @(negedge clk);
      chk("hold_grant", grant, 2'b01);
      chk("hold_s1_arready", s_arready[1], 1'b0);
    end
    @(posedge clk); #1 ar_en = 1'b1;
    wait_idle(300);

    // stray R beats outside DATA must not be accepted or forwarded
    spur = 1'b1;
    @(posedge clk); #1;
    repeat (2) begin
      @(negedge clk);
      chk("spur_idle_rready", m_r_rready, 1'b0);
      chk("spur_idle_rvalid", s_rvalid, 2'b00);
    end
    @(posedge clk); #1 ar_en = 1'b0;
    push_cmd(0, 6'h06, 8'd0, 32'h0000_0600);
    repeat (3) @(posedge clk);
    repeat (2) begin
      @(negedge clk);
      chk("spur_addr_busy", busy, 1'b1);
      chk("spur_addr_rready", m_r_rready, 1'b0);
      chk("spur_addr_rvalid", s_rvalid, 2'b00);
    end
    @(posedge clk); #1;
    spur = 1'b0;
    ar_en = 1'b1;
    wait_idle(300);

    // reset pulse during beat 2 of a four-beat burst
    base = beats_seen[0];
    push_cmd(0, 6'h07, 8'd3, 32'h0000_0700);
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(posedge clk); #1;
      seen = (beats_seen[0] >= base + 1);
    end
    chk("midrst_first_beat", seen, 1'b1);
    rst_n = 1'b0;
    exp_q0.delete();
    @(negedge clk);
    chk_quiet("midrst_hold");
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_grant", grant, 2'b00);
    chk("midrst_err", err_len, 1'b0);
    chk_quiet("midrst_after");
    @(posedge clk); #1;
    push_cmd(1, 6'h17, 8'd1, 32'h1000_0700);
    wait_idle(300);

    // randomized traffic with stalls on both sides
    rand_mode = 1'b1;
    for (int k = 0; k < 50; k++) begin
      push_cmd(0, 6'($urandom_range(0, 63)), 8'($urandom_range(0, 15)), {16'h3000, 16'(k)} << 4);
      push_cmd(1, 6'($urandom_range(0, 63)), 8'($urandom_range(0, 15)), {16'h4000, 16'(k)} << 4);
    end
    wait_idle(30000);
    rand_mode = 1'b0;
    chk("final_q0_empty", exp_q0.size(), 0);
    chk("final_q1_empty", exp_q1.size(), 0);
    chk("final_err", err_len, 1'b0);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
